mem_arbiter: RTL and testbench

- Sequences the single byte-wide memory/IO bus (mem_a/mem_din/mem_dout/mem_wr) between two requesters: instruction fetch (reads) and the load/store buffer (loads and stores).
- Serialises 1/2/4-byte transactions into byte cycles and assembles or disassembles words, little-endian.
- Handles io_buffer_full back-pressure, rdy_in pause and rollback abort.
- Sits between ifetch/LSB and the cpu memory ports.

---
 rtl/mem_arbiter_pkg.sv | 36 +++
 rtl/mem_arbiter.sv | 186 ++++++++++++++++++
 tb/tb_mem_arbiter.sv | 248 ++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_arbiter_pkg.sv
// Shared encodings for the byte-serial memory arbiter: FSM states, grant
// owner, lsb_len codes and the IO-region address compare.
package mem_arbiter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_IF_RD = 2'd1,
    ST_LS_RD = 2'd2,
    ST_LS_WR = 2'd3
  } arb_state_e;

  typedef enum logic {
    GNT_IF  = 1'b0,
    GNT_LSB = 1'b1
  } grant_e;

  localparam logic [1:0] LEN_1B    = 2'b00;
  localparam logic [1:0] LEN_2B    = 2'b01;
  localparam logic [1:0] LEN_4B    = 2'b10;
  localparam logic [1:0] IO_REGION = 2'b11;

  // 2'b11 is treated as a word access.
  function automatic logic [2:0] len_bytes(input logic [1:0] len);
    case (len)
      LEN_1B:  return 3'd1;
      LEN_2B:  return 3'd2;
      LEN_4B:  return 3'd4;
      default: return 3'd4;
    endcase
  endfunction

  function automatic logic is_io(input logic [1:0] addr_hi);
    return addr_hi == IO_REGION;
  endfunction

endpackage

// File: rtl/mem_arbiter.sv
// Arbitrates ifetch and LSB onto the byte-wide memory bus, serialising
// 1/2/4-byte accesses and assembling/disassembling little-endian words.
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int IF_LEN = 4
) (
  input  logic              clk_in,
  input  logic              rst_in,
  input  logic              rdy_in,
  input  logic              rollback,
  input  logic              io_buffer_full,
  input  logic [7:0]        mem_din,
  output logic [7:0]        mem_dout,
  output logic [ADDR_W-1:0] mem_a,
  output logic              mem_wr,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_done,
  output logic [DATA_W-1:0] if_data,
  input  logic              lsb_req,
  input  logic              lsb_we,
  input  logic [ADDR_W-1:0] lsb_addr,
  input  logic [1:0]        lsb_len,
  input  logic [DATA_W-1:0] lsb_wdata,
  output logic              lsb_done,
  output logic [DATA_W-1:0] lsb_rdata
);

  arb_state_e        state_q, state_d;
  grant_e            last_q, last_d;
  logic [2:0]        cnt_q, cnt_d;
  logic [2:0]        len_q, len_d;
  logic [ADDR_W-1:0] mem_a_q, mem_a_d;
  logic [7:0]        mem_dout_q, mem_dout_d;
  logic              mem_wr_q, mem_wr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [DATA_W-1:0] buf_q, buf_d;
  logic              if_done_q, if_done_d;
  logic              lsb_done_q, lsb_done_d;
  logic [DATA_W-1:0] if_data_q, if_data_d;
  logic [DATA_W-1:0] lsb_rdata_q, lsb_rdata_d;

  logic       if_eff, lsb_eff, gnt_if, gnt_lsb, io_stall;
  logic [2:0] cnt_nxt, cnt_prev;

  assign io_stall = (state_q == ST_LS_WR) && is_io(mem_a_q[17:16]) && io_buffer_full;
  assign cnt_nxt  = cnt_q + 3'd1;
  assign cnt_prev = cnt_q - 3'd1;

  // A requester whose done is high is ignored so a held req is not re-granted.
  assign if_eff  = if_req & ~if_done_q & ~rollback;
  assign lsb_eff = lsb_req & ~lsb_done_q & (lsb_we | ~rollback);
  assign gnt_lsb = lsb_eff & (~if_eff | (last_q == GNT_IF));
  assign gnt_if  = if_eff & ~gnt_lsb;

  always_comb begin
    state_d     = state_q;
    last_d      = last_q;
    cnt_d       = cnt_q;
    len_d       = len_q;
    mem_a_d     = mem_a_q;
    mem_dout_d  = mem_dout_q;
    mem_wr_d    = mem_wr_q;
    wdata_d     = wdata_q;
    buf_d       = buf_q;
    if_done_d   = 1'b0;
    lsb_done_d  = 1'b0;
    if_data_d   = if_data_q;
    lsb_rdata_d = lsb_rdata_q;

    case (state_q)
      ST_IDLE: begin
        if (gnt_lsb) begin
          last_d  = GNT_LSB;
          mem_a_d = lsb_addr;
          cnt_d   = '0;
          len_d   = len_bytes(lsb_len);
          buf_d   = '0;
          if (lsb_we) begin
            state_d    = ST_LS_WR;
            mem_wr_d   = 1'b1;
            mem_dout_d = lsb_wdata[7:0];
            wdata_d    = lsb_wdata;
          end else begin
            state_d = ST_LS_RD;
          end
        end else if (gnt_if) begin
          state_d = ST_IF_RD;
          last_d  = GNT_IF;
          mem_a_d = if_addr;
          cnt_d   = '0;
          len_d   = 3'(IF_LEN);
          buf_d   = '0;
        end
      end

      // cnt is the byte on the bus; byte cnt-1 is on mem_din this cycle.
      ST_IF_RD, ST_LS_RD: begin
        if (rollback) begin
          state_d = ST_IDLE;
          mem_a_d = '0;
          cnt_d   = '0;
        end else begin
          if (cnt_q != 3'd0) buf_d[{cnt_prev, 3'b000} +: 8] = mem_din;
          if (cnt_q == len_q) begin
            state_d = ST_IDLE;
            cnt_d   = '0;
            if (state_q == ST_IF_RD) begin
              if_done_d = 1'b1;
              if_data_d = buf_d;
            end else begin
              lsb_done_d  = 1'b1;
              lsb_rdata_d = buf_d;
            end
          end else begin
            cnt_d   = cnt_nxt;
            mem_a_d = (cnt_nxt < len_q) ? mem_a_q + ADDR_W'(1) : '0;
          end
        end
      end

      ST_LS_WR: begin
        if (!io_stall) begin
          if (cnt_q == len_q - 3'd1) begin
            state_d    = ST_IDLE;
            cnt_d      = '0;
            mem_wr_d   = 1'b0;
            mem_a_d    = '0;
            mem_dout_d = '0;
            lsb_done_d = 1'b1;
          end else begin
            cnt_d      = cnt_nxt;
            mem_a_d    = mem_a_q + ADDR_W'(1);
            mem_dout_d = wdata_q[{cnt_nxt, 3'b000} +: 8];
          end
        end
      end

      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      state_q     <= ST_IDLE;
      last_q      <= GNT_IF;
      cnt_q       <= '0;
      len_q       <= '0;
      mem_a_q     <= '0;
      mem_dout_q  <= '0;
      mem_wr_q    <= 1'b0;
      wdata_q     <= '0;
      buf_q       <= '0;
      if_done_q   <= 1'b0;
      lsb_done_q  <= 1'b0;
      if_data_q   <= '0;
      lsb_rdata_q <= '0;
    end else if (rdy_in) begin
      state_q     <= state_d;
      last_q      <= last_d;
      cnt_q       <= cnt_d;
      len_q       <= len_d;
      mem_a_q     <= mem_a_d;
      mem_dout_q  <= mem_dout_d;
      mem_wr_q    <= mem_wr_d;
      wdata_q     <= wdata_d;
      buf_q       <= buf_d;
      if_done_q   <= if_done_d;
      lsb_done_q  <= lsb_done_d;
      if_data_q   <= if_data_d;
      lsb_rdata_q <= lsb_rdata_d;
    end
  end

  assign mem_a     = mem_a_q;
  assign mem_dout  = mem_dout_q;
  assign mem_wr    = mem_wr_q & rdy_in & ~io_stall;
  assign if_done   = if_done_q;
  assign if_data   = if_data_q;
  assign lsb_done  = lsb_done_q;
  assign lsb_rdata = lsb_rdata_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: fetch, arbitration, stores, IO stall,
// rollback, rdy pause and asynchronous reset.
module tb_mem_arbiter;

  logic        clk_in = 1'b0;
  logic        rst_in;
  logic        rdy_in;
  logic        rollback;
  logic        io_buffer_full;
  logic [7:0]  mem_din = '0;
  logic [7:0]  mem_dout;
  logic [31:0] mem_a;
  logic        mem_wr;
  logic        if_req;
  logic [31:0] if_addr;
  logic        if_done;
  logic [31:0] if_data;
  logic        lsb_req;
  logic        lsb_we;
  logic [31:0] lsb_addr;
  logic [1:0]  lsb_len;
  logic [31:0] lsb_wdata;
  logic        lsb_done;
  logic [31:0] lsb_rdata;

  int checks = 0;
  int errors = 0;

  logic [7:0]  mem [0:1023];
  int          wr_cnt = 0;
  logic [31:0] last_wr_a = '0;
  logic [7:0]  last_wr_d = '0;

  mem_arbiter #(.ADDR_W(32), .DATA_W(32), .IF_LEN(4)) dut (
    .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in), .rollback(rollback),
    .io_buffer_full(io_buffer_full), .mem_din(mem_din), .mem_dout(mem_dout),
    .mem_a(mem_a), .mem_wr(mem_wr), .if_req(if_req), .if_addr(if_addr),
    .if_done(if_done), .if_data(if_data), .lsb_req(lsb_req), .lsb_we(lsb_we),
    .lsb_addr(lsb_addr), .lsb_len(lsb_len), .lsb_wdata(lsb_wdata),
    .lsb_done(lsb_done), .lsb_rdata(lsb_rdata)
  );

  always #5 clk_in = ~clk_in;

  // Memory steps with the system, so it pauses along with rdy_in.
  always @(posedge clk_in) begin
    if (rdy_in) begin
      mem_din <= mem[mem_a[9:0]];
      if (mem_wr) begin
        wr_cnt    <= wr_cnt + 1;
        last_wr_a <= mem_a;
        last_wr_d <= mem_dout;
      end
    end
  end

  task automatic tick();
    @(posedge clk_in);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  logic [7:0] st_bytes [4];
  int base;

  initial begin
    for (int i = 0; i < 1024; i++) mem[i] = 8'h00;
    mem[10'h100] = 8'h13; mem[10'h101] = 8'h05; mem[10'h102] = 8'h00; mem[10'h103] = 8'h00;
    mem[10'h104] = 8'h37; mem[10'h105] = 8'h12;
    mem[10'h108] = 8'h93; mem[10'h109] = 8'h00; mem[10'h10A] = 8'h10; mem[10'h10B] = 8'h00;
    st_bytes = '{8'hEF, 8'hBE, 8'hAD, 8'hDE};

    rst_in = 1'b0; rdy_in = 1'b1; rollback = 1'b0; io_buffer_full = 1'b0;
    if_req = 1'b0; if_addr = '0; lsb_req = 1'b0; lsb_we = 1'b0;
    lsb_addr = '0; lsb_len = 2'b00; lsb_wdata = '0;
    #2;
    chk("rst_mem_a", mem_a, 0);
    chk("rst_mem_wr", mem_wr, 0);
    chk("rst_mem_dout", mem_dout, 0);
    chk("rst_if_done", if_done, 0);
    chk("rst_lsb_done", lsb_done, 0);
    chk("rst_if_data", if_data, 0);
    chk("rst_lsb_rdata", lsb_rdata, 0);
    tick();
    rst_in = 1'b1;
    tick();

    // Fetch at 0x100
    if_req = 1'b1; if_addr = 32'h100;
    for (int k = 0; k < 4; k++) begin
      tick();
      chk("fetch_mem_a", mem_a, 32'h100 + k);
      chk("fetch_mem_wr", mem_wr, 0);
    end
    tick();
    chk("fetch_a_zero", mem_a, 0);
    chk("fetch_no_done_c5", if_done, 0);
    tick();
    chk("fetch_done", if_done, 1);
    chk("fetch_data", if_data, 32'h00000513);
    tick();
    chk("fetch_no_regrant", mem_a, 0);
    chk("fetch_done_pulse", if_done, 0);
    if_req = 1'b0;
    tick();

    // Conflict from reset: LSB first, then IF
    rst_in = 1'b0; #1; rst_in = 1'b1;
    lsb_req = 1'b1; lsb_we = 1'b0; lsb_addr = 32'h104; lsb_len = 2'b01;
    if_req = 1'b1; if_addr = 32'h108;
    tick(); chk("arb_lsb_first", mem_a, 32'h104);
    tick(); chk("arb_lsb_b1", mem_a, 32'h105);
    tick(); chk("arb_lsb_a0", mem_a, 0);
    tick();
    chk("arb_lsb_done", lsb_done, 1);
    chk("arb_lsb_rdata", lsb_rdata, 32'h00001237);
    lsb_req = 1'b0;
    tick(); chk("arb_if_next", mem_a, 32'h108);
    lsb_req = 1'b1; lsb_addr = 32'h104; lsb_len = 2'b00;
    tick(); chk("arb_if_not_preempted", mem_a, 32'h109);
    tick(); tick(); tick(); tick();
    chk("arb_if_done", if_done, 1);
    chk("arb_if_data", if_data, 32'h00100093);
    if_req = 1'b0;
    tick(); chk("arb_lsb_after_if", mem_a, 32'h104);
    tick(); tick();
    chk("arb_lsb1_done", lsb_done, 1);
    chk("arb_lsb1_rdata", lsb_rdata, 32'h00000037);
    lsb_req = 1'b0;
    tick();

    // 4-byte store
    lsb_req = 1'b1; lsb_we = 1'b1; lsb_addr = 32'h200; lsb_len = 2'b10; lsb_wdata = 32'hDEADBEEF;
    for (int k = 0; k < 4; k++) begin
      tick();
      chk("st_mem_a", mem_a, 32'h200 + k);
      chk("st_mem_wr", mem_wr, 1);
      chk("st_mem_dout", mem_dout, st_bytes[k]);
      chk("st_no_early_done", lsb_done, 0);
    end
    tick();
    chk("st_done", lsb_done, 1);
    chk("st_wr_off", mem_wr, 0);
    lsb_req = 1'b0;
    tick();

    // IO store with buffer full for 3 cycles
    base = wr_cnt;
    lsb_req = 1'b1; lsb_we = 1'b1; lsb_addr = 32'h30000; lsb_len = 2'b00; lsb_wdata = 32'h00000041;
    io_buffer_full = 1'b1;
    for (int k = 0; k < 3; k++) begin
      tick();
      chk("io_stall_wr", mem_wr, 0);
      chk("io_stall_a", mem_a, 32'h30000);
    end
    tick();
    io_buffer_full = 1'b0;
    #1;
    chk("io_resume_wr", mem_wr, 1);
    chk("io_resume_dout", mem_dout, 8'h41);
    chk("io_no_early_done", lsb_done, 0);
    tick();
    chk("io_done", lsb_done, 1);
    chk("io_wr_count", wr_cnt - base, 1);
    chk("io_wr_addr", last_wr_a, 32'h30000);
    chk("io_wr_data", last_wr_d, 8'h41);
    lsb_req = 1'b0;
    tick();

    // Rollback during fetch after 2 bytes, LSB load pending
    if_req = 1'b1; if_addr = 32'h108;
    lsb_req = 1'b1; lsb_we = 1'b0; lsb_addr = 32'h105; lsb_len = 2'b00;
    tick(); chk("rb_if_granted", mem_a, 32'h108);
    tick(); chk("rb_if_b1", mem_a, 32'h109);
    rollback = 1'b1; if_req = 1'b0;
    tick();
    chk("rb_idle_a", mem_a, 0);
    chk("rb_no_if_done", if_done, 0);
    rollback = 1'b0;
    tick();
    chk("rb_lsb_granted", mem_a, 32'h105);
    chk("rb_no_if_done2", if_done, 0);
    tick(); tick();
    chk("rb_lsb_done", lsb_done, 1);
    chk("rb_lsb_rdata", lsb_rdata, 32'h00000012);
    chk("rb_if_data_held", if_data, 32'h00100093);
    lsb_req = 1'b0;
    tick();

    // Rollback in IDLE: load ignored, store granted
    rollback = 1'b1; lsb_req = 1'b1; lsb_we = 1'b0; lsb_addr = 32'h104; lsb_len = 2'b00;
    tick(); chk("rb_idle_load_ignored", mem_a, 0);
    lsb_we = 1'b1; lsb_addr = 32'h210; lsb_wdata = 32'h0000005A;
    tick();
    chk("rb_idle_store_a", mem_a, 32'h210);
    chk("rb_idle_store_wr", mem_wr, 1);
    chk("rb_idle_store_dout", mem_dout, 8'h5A);
    rollback = 1'b0;
    tick(); chk("rb_idle_store_done", lsb_done, 1);
    lsb_req = 1'b0;
    tick();

    // rdy_in low for 2 cycles mid 4-byte load
    lsb_req = 1'b1; lsb_we = 1'b0; lsb_addr = 32'h100; lsb_len = 2'b10;
    tick(); tick();
    chk("rdy_a_before", mem_a, 32'h101);
    rdy_in = 1'b0;
    tick(); chk("rdy_a_held", mem_a, 32'h101);
    tick(); chk("rdy_a_held2", mem_a, 32'h101);
    rdy_in = 1'b1;
    tick(); tick(); tick();
    chk("rdy_no_early_done", lsb_done, 0);
    tick();
    chk("rdy_done", lsb_done, 1);
    chk("rdy_rdata", lsb_rdata, 32'h00000513);
    lsb_req = 1'b0;
    tick();

    // Reset mid store
    lsb_req = 1'b1; lsb_we = 1'b1; lsb_addr = 32'h200; lsb_len = 2'b10; lsb_wdata = 32'hDEADBEEF;
    tick(); tick();
    chk("rstw_wr_before", mem_wr, 1);
    rst_in = 1'b0;
    #1;
    chk("rstw_mem_wr", mem_wr, 0);
    chk("rstw_mem_a", mem_a, 0);
    chk("rstw_mem_dout", mem_dout, 0);
    chk("rstw_if_data", if_data, 0);
    chk("rstw_lsb_rdata", lsb_rdata, 0);
    lsb_req = 1'b0;
    tick();
    rst_in = 1'b1;
    tick(); tick();
    chk("rstw_no_done", lsb_done, 0);
    chk("rstw_idle_a", mem_a, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
